vram_arbiter: RTL
=================

# vram_arbiter

Arbitrates the single shared video/system RAM port between the CRTC-driven video fetch path and the Z80 CPU bus. Sits between the CPU/CRTC glue and the memory array. Sequences every RAM access as a two-slot address/data transaction on the 8.8 MHz pixel strobe and holds the CPU in wait while video owns the port.

## Interface
- `AW`, 16: RAM address width.
- `STARVE_MAX`, 4: maximum consecutive video grants while a CPU request is pending (used only with `VRAM_ARB_STARVE_EN`).

- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `ce`  in  1  slot strobe, one-clock pulse (pe8M8).
- `de`  in  1  CRTC display enable; selects video priority.
- `vreq`  in  1  video fetch request; level, held until `vack`.
- `va`  in  AW  video fetch address.
- `vack`  out  1  one-clock pulse: `vq` valid.
- `vq`  out  8  video read data.
- `creq`  in  1  CPU memory request (mreq low and rd or wr low); level.
- `cwr`  in  1  1 = CPU write.
- `ca`  in  AW  CPU address.
- `cd`  in  8  CPU write data.
- `cq`  out  8  CPU read data, held until the next CPU access completes.
- `cwait`  out  1  active-high CPU hold.
- `ramA`  out  AW  RAM address.
- `ramD`  out  8  RAM write data.
- `ramWe`  out  1  RAM write enable.
- `ramQ`  in  8  RAM read data; synchronous, valid one clock after `ramA`.

## Operation
- FSM states: IDLE, ACC. All state changes occur only on `ce` clocks.
- IDLE, on `ce`:
  - No request: stay in IDLE.
  - Grant one requester: register `ramA`, `ramD`, and `ramWe` (= `cwr` for CPU grants, 0 for video), record the owner, go to ACC.
- ACC, on `ce`:
  - Clear `ramWe`.
  - Video owner: capture `ramQ` into `vq` and pulse `vack`.
  - CPU owner: capture `ramQ` into `cq` (writes leave `cq` unchanged) and set `cdone`.
  - Return to IDLE.
- Priority:
  - `de`=1: video wins.
  - `de`=0: CPU wins.
  - The loser stays pending and is not dropped.
- `cdone` is set on CPU completion and cleared when `creq` goes low.
- `cwait` = `creq & ~cdone`, combinational, forced to 0 while `reset` is high.
- If `creq` drops mid-access, the access still completes (a write is committed). `cdone` is not set.
- If `vreq` drops mid-access, the access still completes and `vack` still pulses.
- Only one access is ever outstanding. `ramWe` is high for exactly one `ce` period per CPU write.
- Reset: state IDLE, `ramWe`=0, `ramA`=0, `ramD`=0, `vq`=0, `cq`=0, `vack`=0, `cdone`=0, starvation counter=0. A reset mid-access aborts it with no `vack` and no write.

## Timing
- Slot = 4 clocks at 35.2 MHz.
- Access = 2 slots: grant at `ce` T0, data/ack at `ce` T1.
- Next grant is no earlier than T2. Peak throughput is one access per 2 slots.
- `vack` is high for exactly the clock following the T1 `ce` edge.
- Worst-case CPU latency:
  - `de`=0: 4 slots.
  - `de`=1 with `VRAM_ARB_STARVE_EN`: 2·(STARVE_MAX+1) slots + 2.
  - `de`=1 without the macro: unbounded.
- `ramA`, `ramD`, and `ramWe` change only on `ce` clocks or on reset.

## Configuration
- `VRAM_ARB_STARVE_EN` defined:
  - A 3-bit counter increments on each video grant made while `creq` is pending, saturating at STARVE_MAX.
  - When the counter equals STARVE_MAX and `creq` is pending, the CPU wins the next grant regardless of `de`.
  - The counter clears on any CPU grant and whenever `creq` is low.
- Undefined: strict `de`-based priority, no counter logic.

## Test plan
- Idle CPU read, `de`=0:
  - Stimulus: `creq`=1, `cwr`=0, `ca`=0x1234, RAM holds 0x5A.
  - Response: `ramA`=0x1234 at T0; `cq`=0x5A at T1; `cwait` high from `creq` assertion until T1.
- CPU write:
  - Stimulus: `ca`=0x0010, `cd`=0xC3.
  - Response: `ramWe`=1 for exactly one slot with `ramD`=0xC3; readback gives 0xC3.
- Simultaneous `vreq`/`creq` at one `ce`:
  - `de`=1: video granted first, `vack` at T1, CPU granted at T2.
  - `de`=0: reversed order.
- Starvation, macro on, STARVE_MAX=4:
  - Stimulus: `vreq` held continuously, `de`=1, `creq` pending.
  - Response: exactly 4 video grants, then 1 CPU grant, then video resumes.
  - Macro off: the CPU is never granted while `de`=1.
- Reset mid-write:
  - Stimulus: assert `reset` one clock after a T0 CPU write grant.
  - Response: `ramWe` goes to 0 immediately, no `vack`, `cwait`=0, FSM in IDLE after release.
- `creq` dropped during ACC:
  - Response: the write is still committed; the following new `creq` starts with `cdone`=0 and `cwait`=1.

Source files
------------

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single video/system RAM port between the CRTC
// video fetch path and the Z80 CPU bus. Each access occupies two slots of
// the pixel strobe `ce`: the grant slot (address/data/we registered) and the
// data slot (read data captured, requester acknowledged).
//
// Optional feature macro: VRAM_ARB_STARVE_EN. When defined, a starvation
// counter forces a CPU grant after STARVE_MAX consecutive video grants made
// while the CPU was waiting. When undefined, priority follows `de` only.
//
// Handshakes:
//   video: `vreq` is a level held until `vack`. `vack` is a one-clock pulse
//          and `vq` is valid in that clock.
//   cpu:   `creq` is a level for the whole bus cycle. `cwait` stays high
//          until the access completes. `cq` then holds the read data until
//          the next CPU access completes. Lowering `creq` ends the cycle.
// `dbg_state` exposes the FSM state (0 = IDLE, 1 = ACC).
module vram_arbiter #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ce,
    input  logic          de,
    input  logic          vreq,
    input  logic [AW-1:0] va,
    output logic          vack,
    output logic [7:0]    vq,
    input  logic          creq,
    input  logic          cwr,
    input  logic [AW-1:0] ca,
    input  logic [7:0]    cd,
    output logic [7:0]    cq,
    output logic          cwait,
    output logic [AW-1:0] ramA,
    output logic [7:0]    ramD,
    output logic          ramWe,
    input  logic [7:0]    ramQ,
    output logic          dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t        state_q;
    logic          owner_cpu_q;  // owner of the access in flight
    logic          cdone_q;      // CPU access finished, waiting for creq to drop
    logic          cabort_q;     // creq dropped while its access was in flight
    logic [AW-1:0] ram_a_q;
    logic [7:0]    ram_d_q;
    logic          ram_we_q;
    logic [7:0]    vq_q;
    logic [7:0]    cq_q;
    logic          vack_q;

    logic          cpu_pend;
    logic          cpu_force;
    logic          grant_v;
    logic          grant_c;

    // A CPU cycle that already completed is not pending again until creq
    // goes low and comes back.
    assign cpu_pend = creq & ~cdone_q;

`ifdef VRAM_ARB_STARVE_EN
    logic [2:0] starve_q;

    assign cpu_force = cpu_pend & (starve_q == 3'(STARVE_MAX));

    // Count video grants taken while the CPU waits; saturate, clear when the CPU is served or idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= 3'd0;
        end else if (!creq) begin
            starve_q <= 3'd0;
        end else if (ce && state_q == IDLE) begin
            if (grant_c) begin
                starve_q <= 3'd0;
            end else if (grant_v && cpu_pend && starve_q < 3'(STARVE_MAX)) begin
                starve_q <= starve_q + 3'd1;
            end
        end
    end
`else
    assign cpu_force = 1'b0;
`endif

    // Video wins during display unless the CPU is being forced; the loser stays pending.
    assign grant_v = vreq & ~cpu_force & (de | ~cpu_pend);
    assign grant_c = cpu_pend & ~grant_v;

    // Two-slot access sequencer with registered RAM strobes and results.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_cpu_q <= 1'b0;
            cdone_q     <= 1'b0;
            cabort_q    <= 1'b0;
            ram_a_q     <= '0;
            ram_d_q     <= 8'h00;
            ram_we_q    <= 1'b0;
            vq_q        <= 8'h00;
            cq_q        <= 8'h00;
            vack_q      <= 1'b0;
        end else begin
            vack_q <= 1'b0;
            if (!creq) begin
                cdone_q <= 1'b0;
            end
            // Remember a mid-access drop so a quickly re-raised creq is not
            // mistaken for the cycle that just got served.
            if (state_q == ACC && owner_cpu_q && !creq) begin
                cabort_q <= 1'b1;
            end
            if (ce) begin
                case (state_q)
                    IDLE: begin
                        if (grant_v) begin
                            ram_a_q     <= va;
                            ram_we_q    <= 1'b0;
                            owner_cpu_q <= 1'b0;
                            state_q     <= ACC;
                        end else if (grant_c) begin
                            ram_a_q     <= ca;
                            ram_d_q     <= cd;
                            ram_we_q    <= cwr;
                            owner_cpu_q <= 1'b1;
                            cabort_q    <= 1'b0;
                            state_q     <= ACC;
                        end
                    end
                    ACC: begin
                        ram_we_q <= 1'b0;
                        if (owner_cpu_q) begin
                            if (!ram_we_q) begin
                                cq_q <= ramQ;
                            end
                            if (creq && !cabort_q) begin
                                cdone_q <= 1'b1;
                            end
                        end else begin
                            vq_q   <= ramQ;
                            vack_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cwait     = creq & ~cdone_q & ~reset;
    assign ramA      = ram_a_q;
    assign ramD      = ram_d_q;
    assign ramWe     = ram_we_q;
    assign vq        = vq_q;
    assign cq        = cq_q;
    assign vack      = vack_q;
    assign dbg_state = state_q;

endmodule
